sobel_rd_engine: RTL and testbench

Host-memory read engine sitting directly downstream of the Sobel CSR block. It consumes the CSR outputs (control word, input-buffer cache-line address and byte size) and walks the input image buffer with CCI-P RdLine requests on channel 0. It then delivers the returned 512-bit lines, in request order, as a valid/ready stream to the Sobel datapath. Completion is reported as a level for the DSM/status writer.

---
 rtl/sobel_pkg.sv | 73 +++++++
 rtl/sobel_rd_fifo.sv | 73 +++++++
 rtl/sobel_rd_engine.sv | 170 +++++++++++++++++
 tb/tb_sobel_rd_engine.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared types for the Sobel host-read path: the CCI-P channel-0 structures
// the engine drives and consumes, plus engine state and control constants.
package sobel_pkg;

  typedef enum logic [1:0] {
    eVC_VA  = 2'b00,
    eVC_VL0 = 2'b01,
    eVC_VH0 = 2'b10,
    eVC_VH1 = 2'b11
  } t_ccip_vc;

  typedef enum logic [1:0] {
    eCL_LEN_1 = 2'b00,
    eCL_LEN_2 = 2'b01,
    eCL_LEN_4 = 2'b11
  } t_ccip_clLen;

  typedef enum logic [3:0] {
    eREQ_RDLINE_I = 4'h0,
    eREQ_RDLINE_S = 4'h1
  } t_ccip_c0_req;

  typedef enum logic [3:0] {
    eRSP_RDLINE = 4'h0,
    eRSP_UMSG   = 4'h4
  } t_ccip_c0_rsp;

  typedef struct packed {
    t_ccip_vc     vc_sel;
    logic [1:0]   rsvd1;
    t_ccip_clLen  cl_len;
    t_ccip_c0_req req_type;
    logic [5:0]   rsvd0;
    logic [41:0]  address;
    logic [15:0]  mdata;
  } t_ccip_c0_ReqMemHdr;

  typedef struct packed {
    t_ccip_c0_ReqMemHdr hdr;
    logic               valid;
  } t_if_ccip_c0_Tx;

  typedef struct packed {
    t_ccip_vc     vc_used;
    logic         rsvd1;
    logic         hit_miss;
    logic [1:0]   rsvd0;
    logic [1:0]   cl_num;
    t_ccip_c0_rsp resp_type;
    logic [15:0]  mdata;
  } t_ccip_c0_RspMemHdr;

  typedef struct packed {
    t_ccip_c0_RspMemHdr hdr;
    logic [511:0]       data;
    logic               rspValid;
    logic               mmioRdValid;
    logic               mmioWrValid;
  } t_if_ccip_c0_Rx;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_RUN,
    RD_DRAIN,
    RD_DONE
  } t_rd_state;

  localparam int          HC_CTRL_RUN_BIT = 0;
  localparam logic [15:0] RD_MDATA_TAG    = 16'h5B01;

  typedef logic [26:0] t_hc_lines;

endpackage

// File: rtl/sobel_rd_fifo.sv
// Line buffer between the response channel and the datapath stream. The head
// entry sits in an output register so data is presented first-word-fall-through.
module sobel_rd_fifo #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 64,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_pushData,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [CW-1:0]    o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [CW-1:0]    r_memCount;
  logic             r_outValid;
  logic [WIDTH-1:0] r_outData;

  logic w_pop;
  logic w_memEmpty;
  logic w_loadOut;
  logic w_memRead;
  logic w_bypass;
  logic w_memWrite;

  // An empty output slot is refilled from memory first; a push only skips
  // memory when nothing older is waiting there, which keeps lines in order.
  assign w_pop      = i_ready & r_outValid;
  assign w_memEmpty = (r_memCount == '0);
  assign w_loadOut  = ~r_outValid | w_pop;
  assign w_memRead  = w_loadOut & ~w_memEmpty;
  assign w_bypass   = w_loadOut & w_memEmpty & i_push;
  assign w_memWrite = i_push & ~w_bypass;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_memCount <= '0;
      r_outValid <= 1'b0;
    end else begin
      if (w_memWrite) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_memRead)  r_rdPtr <= r_rdPtr + 1'b1;
      if (w_loadOut)  r_outValid <= ~w_memEmpty | i_push;
      r_memCount <= r_memCount + CW'(w_memWrite) - CW'(w_memRead);
    end
  end

  always_ff @(posedge clk) begin
    if (w_memWrite) r_mem[r_wrPtr] <= i_pushData;
    if (w_memRead) begin
      r_outData <= r_mem[r_rdPtr];
    end else if (w_bypass) begin
      r_outData <= i_pushData;
    end
  end

  assign o_valid = r_outValid;
  assign o_data  = r_outData;
  assign o_count = r_memCount + CW'(r_outValid);

  // Upstream credit accounting must never let a push land on a full buffer.
  assert property (@(posedge clk) disable iff (reset)
    !(i_push && !w_pop && (o_count == CW'(DEPTH))));

endmodule

// File: rtl/sobel_rd_engine.sv
// Walks the Sobel input buffer with in-order RdLine requests and streams the
// returned lines to the datapath, reporting busy/done for the status writer.
module sobel_rd_engine
  import sobel_pkg::*;
#(
  parameter int          FIFO_DEPTH      = 64,
  parameter int          MAX_OUTSTANDING = 32,
  parameter logic [15:0] MDATA_TAG       = RD_MDATA_TAG
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [31:0]    hc_control,
  input  logic [41:0]    src_address,
  input  logic [31:0]    src_size,
  output t_if_ccip_c0_Tx c0Tx,
  input  logic           c0TxAlmFull,
  input  t_if_ccip_c0_Rx c0Rx,
  output logic           out_valid,
  output logic [511:0]   out_data,
  input  logic           out_ready,
  output logic           busy,
  output logic           done,
  output t_hc_lines      lines_total
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  t_rd_state      r_state;
  t_hc_lines      r_linesTotal;
  t_hc_lines      r_reqCnt;
  t_hc_lines      r_rspCnt;
  t_hc_lines      r_outCnt;
  logic [41:0]    r_base;
  logic           r_runD1;
  logic           r_runD2;
  logic           r_rspValid;
  logic [511:0]   r_rspData;
  t_if_ccip_c0_Tx r_c0Tx;
  logic           r_busy;
  logic           r_done;

  logic [CW-1:0]  w_fifoCount;
  logic           w_pop;
  logic           w_startEdge;
  logic           w_rspMatch;
  logic           w_creditOk;
  logic           w_issue;
  t_hc_lines      w_newLines;
  t_hc_lines      w_outstanding;
  logic           w_unusedInputs;

  assign w_startEdge = r_runD1 & ~r_runD2;
  assign w_newLines  = t_hc_lines'(({5'b0, src_size} + 37'd63) >> 6);
  assign w_pop       = out_valid & out_ready;

  assign w_rspMatch = c0Rx.rspValid
                    && (c0Rx.hdr.resp_type == eRSP_RDLINE)
                    && (c0Rx.hdr.mdata == MDATA_TAG)
                    && ((r_state == RD_RUN) || (r_state == RD_DRAIN));

  // A request holds a buffer slot from its issue cycle until its line is
  // popped, so the buffer can never be oversubscribed by in-flight reads.
  assign w_outstanding = r_reqCnt - r_rspCnt;
  assign w_creditOk    = (w_outstanding < t_hc_lines'(MAX_OUTSTANDING))
                      && (({1'b0, w_outstanding} + 28'(w_fifoCount)) < 28'(FIFO_DEPTH));
  assign w_issue       = (r_state == RD_RUN) && !c0TxAlmFull && w_creditOk
                      && (r_reqCnt != r_linesTotal);

  assign w_unusedInputs = ^{hc_control[31:1], c0Rx.hdr.vc_used, c0Rx.hdr.rsvd1,
                            c0Rx.hdr.hit_miss, c0Rx.hdr.rsvd0, c0Rx.hdr.cl_num,
                            c0Rx.mmioRdValid, c0Rx.mmioWrValid};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rspValid <= 1'b0;
    end else begin
      r_rspValid <= w_rspMatch;
    end
  end

  always_ff @(posedge clk) begin
    r_rspData <= c0Rx.data;
  end

  // Job control FSM; request header, busy and done are all registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= RD_IDLE;
      r_linesTotal <= '0;
      r_reqCnt     <= '0;
      r_rspCnt     <= '0;
      r_outCnt     <= '0;
      r_base       <= '0;
      r_runD1      <= 1'b0;
      r_runD2      <= 1'b0;
      r_c0Tx       <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_runD1 <= hc_control[HC_CTRL_RUN_BIT];
      r_runD2 <= r_runD1;

      r_c0Tx.valid            <= w_issue;
      r_c0Tx.hdr.vc_sel       <= eVC_VA;
      r_c0Tx.hdr.cl_len       <= eCL_LEN_1;
      r_c0Tx.hdr.req_type     <= eREQ_RDLINE_I;
      r_c0Tx.hdr.address      <= r_base + 42'(r_reqCnt);
      r_c0Tx.hdr.mdata        <= MDATA_TAG;

      if (w_issue)    r_reqCnt <= r_reqCnt + 1'b1;
      if (r_rspValid) r_rspCnt <= r_rspCnt + 1'b1;
      if (w_pop)      r_outCnt <= r_outCnt + 1'b1;

      unique case (r_state)
        RD_IDLE: begin
          if (w_startEdge) begin
            r_linesTotal <= w_newLines;
            r_base       <= src_address;
            r_reqCnt     <= '0;
            r_rspCnt     <= '0;
            r_outCnt     <= '0;
            if (w_newLines == '0) begin
              r_state <= RD_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= RD_RUN;
              r_busy  <= 1'b1;
            end
          end
        end
        RD_RUN: begin
          if (w_issue && ((r_reqCnt + 1'b1) == r_linesTotal)) r_state <= RD_DRAIN;
        end
        RD_DRAIN: begin
          if (w_pop && ((r_outCnt + 1'b1) == r_linesTotal)) begin
            r_state <= RD_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        RD_DONE: begin
          if (!hc_control[HC_CTRL_RUN_BIT]) begin
            r_state <= RD_IDLE;
            r_done  <= 1'b0;
          end
        end
        default: r_state <= RD_IDLE;
      endcase
    end
  end

  sobel_rd_fifo #(
    .WIDTH (512),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_push     (r_rspValid),
    .i_pushData (r_rspData),
    .i_ready    (out_ready),
    .o_valid    (out_valid),
    .o_data     (out_data),
    .o_count    (w_fifoCount)
  );

  assign c0Tx        = r_c0Tx;
  assign busy        = r_busy;
  assign done        = r_done;
  assign lines_total = r_linesTotal;

endmodule

// File: tb/tb_sobel_rd_engine.sv
// Scoreboard bench for sobel_rd_engine: a host-memory responder model answers
// requests in order, and monitors compare requests and delivered lines.
module tb_sobel_rd_engine;
  import sobel_pkg::*;

  localparam int          FIFO_DEPTH = 64;
  localparam int          MAX_OUT    = 32;
  localparam logic [15:0] TAG        = 16'h5B01;

  logic           clk = 1'b0;
  logic           reset;
  logic [31:0]    hc_control;
  logic [41:0]    src_address;
  logic [31:0]    src_size;
  t_if_ccip_c0_Tx c0Tx;
  logic           c0TxAlmFull;
  t_if_ccip_c0_Rx c0Rx;
  logic           out_valid;
  logic [511:0]   out_data;
  logic           out_ready;
  logic           busy;
  logic           done;
  logic [26:0]    lines_total;

  sobel_rd_engine #(
    .FIFO_DEPTH      (FIFO_DEPTH),
    .MAX_OUTSTANDING (MAX_OUT),
    .MDATA_TAG       (TAG)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .hc_control  (hc_control),
    .src_address (src_address),
    .src_size    (src_size),
    .c0Tx        (c0Tx),
    .c0TxAlmFull (c0TxAlmFull),
    .c0Rx        (c0Rx),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .busy        (busy),
    .done        (done),
    .lines_total (lines_total)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [41:0] addr;
    longint      due;
  } t_pend;

  int           checks   = 0;
  int           failures = 0;
  longint       cycle    = 0;
  t_pend        pendQ[$];
  logic [41:0]  expAddrQ[$];
  logic [511:0] expLineQ[$];
  int           jobIssued = 0;
  int           jobRsp    = 0;
  int           jobPopped = 0;
  longint       expLines  = 0;
  logic [31:0]  salt      = 32'h1234_5678;
  bit           holdResp  = 1'b0;
  bit           injectBad = 1'b0;
  int           readyPct  = 100;
  int           almPct    = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Memory image: each line's content is a pure function of its address.
  function automatic logic [511:0] lineData(input logic [41:0] a, input logic [31:0] s);
    logic [511:0] d;
    for (int i = 0; i < 16; i++) begin
      d[i*32 +: 32] = (a[31:0] * 32'h9E37_79B1) ^ s ^ (32'(i) << 24) ^ {22'b0, a[41:32]};
    end
    return d;
  endfunction

  function automatic logic [41:0] rand42();
    return {$urandom_range(0, 1023), $urandom()};
  endfunction

  task automatic applyStimulus(input logic [41:0] base, input logic [31:0] size);
    logic [41:0] a;
    expLines  = (longint'(size) + 63) / 64;
    salt      = $urandom();
    jobIssued = 0;
    jobRsp    = 0;
    jobPopped = 0;
    for (longint i = 0; i < expLines; i++) begin
      a = base + 42'(i);
      expAddrQ.push_back(a);
      expLineQ.push_back(lineData(a, salt));
    end
    src_address = base;
    src_size    = size;
    hc_control  = 32'h1 | ($urandom() & 32'hFFFF_FFFE);
  endtask

  task automatic waitDone(input string name, input int budget);
    int n = 0;
    while (n < budget) begin
      @(negedge clk);
      if (done) break;
      n++;
    end
    if (!done) $display("[TB] job %s: cycle budget expired", name);
    checkOutput({name, "_done"}, done, 1);
    checkOutput({name, "_busy_low"}, busy, 0);
    checkOutput({name, "_lines_total"}, lines_total, expLines);
    checkOutput({name, "_reqs_left"}, expAddrQ.size(), 0);
    checkOutput({name, "_lines_left"}, expLineQ.size(), 0);
  endtask

  task automatic endJob();
    @(posedge clk); #1;
    hc_control = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("done_clears", done, 0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_c0tx_valid"}, c0Tx.valid, 0);
    checkOutput({tag, "_out_valid"}, out_valid, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_lines_total"}, lines_total, 0);
  endtask

  // Host memory: answers requests in order after a random latency and drives
  // the random back-pressure / ready patterns.
  initial begin
    t_pend p;
    c0Rx        = '0;
    c0TxAlmFull = 1'b0;
    out_ready   = 1'b1;
    forever begin
      @(posedge clk); #1;
      cycle++;
      c0Rx = '0;
      if (!holdResp && (pendQ.size() > 0) && (pendQ[0].due <= cycle)) begin
        p = pendQ.pop_front();
        c0Rx.rspValid      = 1'b1;
        c0Rx.hdr.resp_type = eRSP_RDLINE;
        c0Rx.hdr.mdata     = TAG;
        c0Rx.data          = lineData(p.addr, salt);
        jobRsp++;
      end else if (injectBad && ($urandom_range(0, 3) == 0)) begin
        c0Rx.rspValid      = 1'b1;
        c0Rx.hdr.resp_type = eRSP_RDLINE;
        c0Rx.hdr.mdata     = TAG ^ (16'h1 << $urandom_range(0, 15));
        c0Rx.data          = {16{$urandom()}};
      end
      c0TxAlmFull = ($urandom_range(0, 99) < almPct);
      out_ready   = ($urandom_range(0, 99) < readyPct);
    end
  end

  // Request monitor: order, header, back-pressure and credit limits.
  initial begin
    t_pend       p;
    logic [41:0] ea;
    bit          prevAlm = 1'b0;
    forever begin
      @(negedge clk);
      if (prevAlm) checkOutput("almfull_blocks_issue", c0Tx.valid, 0);
      if (c0Tx.valid) begin
        jobIssued++;
        if (expAddrQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_req actual=%h required=none", c0Tx.hdr.address);
        end else begin
          ea = expAddrQ.pop_front();
          checkOutput("req_addr", c0Tx.hdr.address, ea);
          checkOutput("req_hdr", {c0Tx.hdr.req_type, c0Tx.hdr.mdata, c0Tx.hdr.cl_len, c0Tx.hdr.vc_sel},
                      {eREQ_RDLINE_I, TAG, eCL_LEN_1, eVC_VA});
        end
        p.addr = c0Tx.hdr.address;
        p.due  = cycle + longint'($urandom_range(1, 8));
        pendQ.push_back(p);
        checkOutput("fifo_credit", (jobIssued - jobPopped) <= FIFO_DEPTH, 1);
        checkOutput("max_outstanding", (jobIssued - jobRsp) <= MAX_OUT, 1);
      end
      prevAlm = c0TxAlmFull;
    end
  end

  // Output monitor: every accepted line must be the next expected one.
  initial begin
    logic [511:0] el;
    forever begin
      @(negedge clk);
      if (!reset && out_valid && out_ready) begin
        jobPopped++;
        checks++;
        if (expLineQ.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpected_line actual=%h required=none", out_data[63:0]);
        end else begin
          el = expLineQ.pop_front();
          if (out_data !== el) begin
            failures++;
            $display("[TB] FAIL line_data idx=%0d actual=%h required=%h", jobPopped - 1, out_data, el);
          end
        end
      end
    end
  end

  initial begin
    #5_000_000;
    failures++;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic [41:0] base;
    int n;
    reset       = 1'b1;
    hc_control  = 32'h0;
    src_address = '0;
    src_size    = '0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkResetValues("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    $display("[TB] size 256: four lines, start latency");
    @(posedge clk); #1;
    base = rand42();
    applyStimulus(base, 32'd256);
    @(negedge clk);
    @(negedge clk);
    checkOutput("no_req_n1", c0Tx.valid, 0);
    @(negedge clk);
    checkOutput("busy_in_run", busy, 1);
    checkOutput("no_req_n2", c0Tx.valid, 0);
    @(negedge clk);
    checkOutput("first_req_n3", c0Tx.valid, 1);
    waitDone("s256", 300);
    endJob();

    $display("[TB] size 65: two lines");
    @(posedge clk); #1;
    applyStimulus(rand42(), 32'd65);
    waitDone("s65", 300);
    endJob();

    $display("[TB] size 0: straight to done");
    @(posedge clk); #1;
    applyStimulus(rand42(), 32'd0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("zero_done_n1", done, 0);
    @(negedge clk);
    checkOutput("zero_done_n2", done, 1);
    waitDone("s0", 10);
    endJob();

    $display("[TB] 100 lines with consumer stalled");
    readyPct = 0;
    @(posedge clk); #1;
    applyStimulus(rand42(), 32'd6400);
    repeat (400) @(negedge clk);
    checkOutput("credit_stop_count", jobIssued, FIFO_DEPTH);
    readyPct = 100;
    waitDone("s6400", 3000);
    endJob();

    $display("[TB] random almfull and ready, address wrap");
    almPct   = 20;
    readyPct = 70;
    @(posedge clk); #1;
    applyStimulus(42'h3FF_FFFF_FFE0, $urandom_range(40 * 64 - 30, 40 * 64));
    waitDone("almfull", 5000);
    almPct   = 0;
    readyPct = 100;
    endJob();

    $display("[TB] foreign mdata injected");
    injectBad = 1'b1;
    @(posedge clk); #1;
    applyStimulus(rand42(), 32'd1280);
    waitDone("badtag", 2000);
    injectBad = 1'b0;
    endJob();

    $display("[TB] reset with requests in flight");
    holdResp = 1'b1;
    @(posedge clk); #1;
    applyStimulus(rand42(), 32'd2560);
    n = 0;
    while ((jobIssued < 10) && (n < 200)) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ten_in_flight", jobIssued >= 10, 1);
    @(posedge clk); #1;
    reset      = 1'b1;
    hc_control = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkResetValues("midrun_reset");
    expAddrQ.delete();
    expLineQ.delete();
    @(posedge clk); #1;
    reset    = 1'b0;
    holdResp = 1'b0;
    n = 0;
    while ((pendQ.size() > 0) && (n < 500)) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(negedge clk);
    checkOutput("late_rsp_no_out", out_valid, 0);
    checkOutput("late_rsp_idle", busy, 0);
    @(posedge clk); #1;
    applyStimulus(rand42(), 32'd640);
    waitDone("restart", 500);
    endJob();

    $display("[TB] random jobs");
    for (int j = 0; j < 3; j++) begin
      almPct   = $urandom_range(0, 30);
      readyPct = $urandom_range(40, 100);
      @(posedge clk); #1;
      applyStimulus(rand42(), $urandom_range(1, 3000));
      waitDone("random", 5000);
      endJob();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
